// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 32;

   // Sized wide enough to be sliced down to any WIDTH up to 64.
   localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, select.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_prem,
   input  logic             i_dvd_bit,
   input  logic [WIDTH-1:0] i_divisor_mag,
   output logic [WIDTH-1:0] o_prem,
   output logic             o_q_bit
);

   logic [WIDTH:0] w_shifted;
   logic [WIDTH:0] w_trial;

   // prem < divisor_mag always holds, so the trial fits WIDTH+1 bits and its MSB is the sign.
   assign w_shifted = {i_prem, i_dvd_bit};
   assign w_trial   = w_shifted - {1'b0, i_divisor_mag};
   assign o_q_bit   = ~w_trial[WIDTH];
   assign o_prem    = o_q_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned restoring divider, one quotient bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_prem;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dsr_mag;
   logic             r_q_neg;
   logic             r_r_neg;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_div_by_zero;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;

   logic             w_dvd_neg;
   logic             w_dsr_neg;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dsr_mag;
   logic [WIDTH-1:0] w_prem_next;
   logic             w_q_bit;

   assign w_dvd_neg = signed_op & dividend[WIDTH-1];
   assign w_dsr_neg = signed_op & divisor[WIDTH-1];
   assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
   assign w_dsr_mag = w_dsr_neg ? -divisor : divisor;

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .i_prem       (r_prem),
      .i_dvd_bit    (r_dvd[WIDTH-1]),
      .i_divisor_mag(r_dsr_mag),
      .o_prem       (w_prem_next),
      .o_q_bit      (w_q_bit)
   );

   // r_dvd shifts the dividend magnitude out at the top while quotient bits fill in at the bottom.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_prem        <= '0;
         r_dvd         <= '0;
         r_dsr_mag     <= '0;
         r_q_neg       <= 1'b0;
         r_r_neg       <= 1'b0;
         r_in_ready    <= 1'b1;
         r_out_valid   <= 1'b0;
         r_div_by_zero <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_in_ready <= 1'b0;
                  r_q_neg    <= w_dvd_neg ^ w_dsr_neg;
                  r_r_neg    <= w_dvd_neg;
                  r_dvd      <= w_dvd_mag;
                  r_dsr_mag  <= w_dsr_mag;
                  r_prem     <= '0;
                  if (divisor == '0) begin
                     r_quotient    <= DIV0_QUOTIENT[WIDTH-1:0];
                     r_remainder   <= dividend;
                     r_div_by_zero <= 1'b1;
                     r_state       <= DONE;
                  end else begin
                     r_cnt         <= CNT_W'(WIDTH);
                     r_div_by_zero <= 1'b0;
                     r_state       <= CALC;
                  end
               end
            end

            CALC: begin
               if (r_cnt != '0) begin
                  r_prem <= w_prem_next;
                  r_dvd  <= {r_dvd[WIDTH-2:0], w_q_bit};
                  r_cnt  <= r_cnt - CNT_W'(1);
               end else begin
                  r_quotient  <= r_q_neg ? -r_dvd : r_dvd;
                  r_remainder <= r_r_neg ? -r_prem : r_prem;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end

            DONE: begin
               // The divide-by-zero shortcut lands here with out_valid still low.
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_div_by_zero;

endmodule
